// File: rtl/dlx_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// dlx_hazard_ctrl
//   Pipeline hazard sequencer for the 5-stage DLX core. It looks at the
//   instruction in IF and the instruction held in IF/ID, and drives the
//   pipeline register write-enables. It handles three hazards:
//     * load-use   : hold PC and IF/ID, inject LU_STALL_CYCLES bubbles into ID/EX
//     * branch     : flush IF/ID when a branch resolves taken
//     * memory wait: freeze the whole pipeline while data memory is busy
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     defined   -> bubble_cnt is a saturating 16-bit count of injected bubbles
//     undefined -> no counter flops, bubble_cnt is tied to zero
//
// Parameters
//   LU_STALL_CYCLES  bubbles per load-use hazard (legal range 1..7)
//   LW_OPCODE        opcode that creates a load-use hazard
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   if_opcode/rs/rt  fields of the instruction in IF
//   id_opcode/id_rt  opcode and load destination held in IF/ID
//   br_taken         branch resolved taken this cycle
//   mem_busy         data memory not ready, whole pipeline holds
//   pc_we, ifid_we   PC and IF/ID write enables
//   pipe_we          ID/EX, EX/MEM, MEM/WB write enable
//   idex_bubble      load a NOP into ID/EX
//   ifid_flush       load a NOP into IF/ID
//   stall_id         idex_bubble delayed one cycle (lines up with EX)
//   bubble_cnt       bubble counter (zero when the feature is not built)
//
// Handshake note: there is no valid/ready pair here; mem_busy acts as a
// level "not ready" from data memory and every enable is combinational from
// the current state and inputs, so a hold takes effect in the detecting cycle.
// -----------------------------------------------------------------------------
module dlx_hazard_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter logic [5:0]  LW_OPCODE       = 6'b100011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  if_opcode,
    input  logic [4:0]  if_rs,
    input  logic [4:0]  if_rt,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rt,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        pipe_we,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        stall_id,
    output logic [15:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Remaining bubbles after the first one, loaded on entry to STALL.
    localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       rt_is_src;
    logic       load_use;
    logic       pc_we_c, ifid_we_c, pipe_we_c, bubble_c, flush_c;

    // rt is a source operand only for R-type, beq, bne and sw; for other
    // opcodes (e.g. lw) it is a destination and cannot cause a hazard.
    always_comb begin
        rt_is_src = (if_opcode == 6'b000000) || (if_opcode == 6'b000100) ||
                    (if_opcode == 6'b000101) || (if_opcode == 6'b101011);
        load_use  = (id_opcode == LW_OPCODE) && (id_rt != 5'd0) &&
                    ((if_rs == id_rt) || (rt_is_src && (if_rt == id_rt)));
    end

    always_comb begin
        pc_we_c   = 1'b0;
        ifid_we_c = 1'b0;
        pipe_we_c = 1'b0;
        bubble_c  = 1'b0;
        flush_c   = 1'b0;
        state_nx  = state;
        cnt_nx    = cnt;
        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    state_nx = ST_MEM_WAIT;
                end else if (br_taken) begin
                    pc_we_c   = 1'b1;
                    ifid_we_c = 1'b1;
                    pipe_we_c = 1'b1;
                    flush_c   = 1'b1;
                end else if (load_use) begin
                    pipe_we_c = 1'b1;
                    bubble_c  = 1'b1;
                    if (LU_STALL_CYCLES > 1) begin
                        state_nx = ST_STALL;
                        cnt_nx   = LU_RELOAD;
                    end
                end else begin
                    pc_we_c   = 1'b1;
                    ifid_we_c = 1'b1;
                    pipe_we_c = 1'b1;
                end
            end
            ST_STALL: begin
                // A busy memory freezes the stall in place; it resumes
                // without a release cycle because state stays STALL.
                if (mem_busy) begin
                    state_nx = ST_STALL;
                end else if (br_taken) begin
                    // The flush kills the dependent instruction, so the
                    // remaining bubbles are dropped.
                    pc_we_c   = 1'b1;
                    ifid_we_c = 1'b1;
                    pipe_we_c = 1'b1;
                    flush_c   = 1'b1;
                    state_nx  = ST_RUN;
                    cnt_nx    = 3'd0;
                end else begin
                    pipe_we_c = 1'b1;
                    bubble_c  = 1'b1;
                    cnt_nx    = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nx = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Full freeze including the release cycle.
                if (!mem_busy) begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    // Enables are forced low for as long as reset is held.
    assign pc_we       = rst_n & pc_we_c;
    assign ifid_we     = rst_n & ifid_we_c;
    assign pipe_we     = rst_n & pipe_we_c;
    assign idex_bubble = rst_n & bubble_c;
    assign ifid_flush  = rst_n & flush_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            cnt      <= 3'd0;
            stall_id <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            stall_id <= idex_bubble;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'h0000;
        end else if (idex_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for dlx_hazard_ctrl. Two instances share all inputs: one with
// LU_STALL_CYCLES=1 (index 0) and one with LU_STALL_CYCLES=3 (index 1).
// A behavioural model tracks, per instance, the number of pending bubbles,
// whether a memory-wait release is owed, and the bubble count.
// -----------------------------------------------------------------------------
module tb_dlx_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  if_opcode = 6'b001000;
    logic [4:0]  if_rs = 5'd1;
    logic [4:0]  if_rt = 5'd2;
    logic [5:0]  id_opcode = 6'b000000;
    logic [4:0]  id_rt = 5'd0;
    logic        br_taken = 1'b0;
    logic        mem_busy = 1'b0;

    logic        a_pc_we, a_ifid_we, a_pipe_we, a_bub, a_flush, a_stall_id;
    logic        b_pc_we, b_ifid_we, b_pipe_we, b_bub, b_flush, b_stall_id;
    logic [15:0] a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dlx_hazard_ctrl #(.LU_STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .if_opcode(if_opcode), .if_rs(if_rs),
        .if_rt(if_rt), .id_opcode(id_opcode), .id_rt(id_rt),
        .br_taken(br_taken), .mem_busy(mem_busy), .pc_we(a_pc_we),
        .ifid_we(a_ifid_we), .pipe_we(a_pipe_we), .idex_bubble(a_bub),
        .ifid_flush(a_flush), .stall_id(a_stall_id), .bubble_cnt(a_cnt)
    );

    dlx_hazard_ctrl #(.LU_STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .if_opcode(if_opcode), .if_rs(if_rs),
        .if_rt(if_rt), .id_opcode(id_opcode), .id_rt(id_rt),
        .br_taken(br_taken), .mem_busy(mem_busy), .pc_we(b_pc_we),
        .ifid_we(b_ifid_we), .pipe_we(b_pipe_we), .idex_bubble(b_bub),
        .ifid_flush(b_flush), .stall_id(b_stall_id), .bubble_cnt(b_cnt)
    );

    // Actual outputs, bit order {pc_we, ifid_we, pipe_we, bubble, flush}
    logic [4:0]  act_c  [2];
    logic        act_sid[2];
    logic [15:0] act_cnt[2];
    always_comb begin
        act_c[0]   = {a_pc_we, a_ifid_we, a_pipe_we, a_bub, a_flush};
        act_c[1]   = {b_pc_we, b_ifid_we, b_pipe_we, b_bub, b_flush};
        act_sid[0] = a_stall_id;
        act_sid[1] = b_stall_id;
        act_cnt[0] = a_cnt;
        act_cnt[1] = b_cnt;
    end

    // Model state
    int         lu_len [2];
    int         pend   [2];
    bit         mw     [2];
    int         bcnt   [2];
    bit         prevb  [2];
    logic [4:0] exp_c  [2];

    function automatic bit model_load_use();
        bit src;
        src = (if_opcode == 6'd0) || (if_opcode == 6'd4) ||
              (if_opcode == 6'd5) || (if_opcode == 6'd43);
        return (id_opcode == 6'd35) && (id_rt != 0) &&
               ((if_rs == id_rt) || (src && (if_rt == id_rt)));
    endfunction

    function automatic void model_calc(int k);
        if (!rst_n || mw[k] || mem_busy)  exp_c[k] = 5'b00000;
        else if (br_taken)                exp_c[k] = 5'b11101;
        else if (pend[k] > 0 || model_load_use()) exp_c[k] = 5'b00110;
        else                              exp_c[k] = 5'b11100;
    endfunction

    function automatic void model_step(int k);
        if (!rst_n) begin
            pend[k] = 0; mw[k] = 0; bcnt[k] = 0; prevb[k] = 0;
            return;
        end
        prevb[k] = exp_c[k][1];
        if (exp_c[k][1] && bcnt[k] != 65535) bcnt[k]++;
        if (mw[k])                mw[k] = mem_busy;
        else if (mem_busy)        begin if (pend[k] == 0) mw[k] = 1; end
        else if (br_taken)        pend[k] = 0;
        else if (pend[k] > 0)     pend[k]--;
        else if (model_load_use()) pend[k] = lu_len[k] - 1;
    endfunction

    task automatic check_cycle();
        logic [15:0] ecnt;
        logic        esid;
        for (int k = 0; k < 2; k++) begin
            model_calc(k);
            esid = rst_n ? prevb[k] : 1'b0;
`ifdef HAZARD_PERF_CNT_EN
            ecnt = rst_n ? 16'(bcnt[k]) : 16'h0;
`else
            ecnt = 16'h0;
`endif
            checks++;
            if (act_c[k] !== exp_c[k]) begin
                errors++;
                $display("FAIL enables[%0d] t=%0t got %b want %b", k, $time, act_c[k], exp_c[k]);
            end
            checks++;
            if (act_sid[k] !== esid) begin
                errors++;
                $display("FAIL stall_id[%0d] t=%0t got %b want %b", k, $time, act_sid[k], esid);
            end
            checks++;
            if (act_cnt[k] !== ecnt) begin
                errors++;
                $display("FAIL bubble_cnt[%0d] t=%0t got %0d want %0d", k, $time, act_cnt[k], ecnt);
            end
            model_step(k);
        end
    endtask

    task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // One clock cycle: drive after the rising edge, check at the falling edge.
    task automatic cycle(input logic rst, input logic [5:0] ifo, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [5:0] ido, input logic [4:0] idrt,
                         input logic br, input logic mb);
        @(posedge clk);
        #1;
        rst_n = rst; if_opcode = ifo; if_rs = rs; if_rt = rt;
        id_opcode = ido; id_rt = idrt; br_taken = br; mem_busy = mb;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input logic mb);
        cycle(1'b1, 6'b001000, 5'd1, 5'd2, 6'b000000, 5'd0, 1'b0, mb);
    endtask

    task automatic hazard(input logic br);
        cycle(1'b1, 6'b000000, 5'd1, 5'd5, 6'b100011, 5'd5, br, 1'b0);
    endtask

    logic [5:0] ops [6];

    initial begin
        lu_len[0] = 1; lu_len[1] = 3;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; mw[k] = 0; bcnt[k] = 0; prevb[k] = 0; exp_c[k] = 0;
        end
        ops[0] = 6'b000000; ops[1] = 6'b000100; ops[2] = 6'b000101;
        ops[3] = 6'b101011; ops[4] = 6'b100011; ops[5] = 6'b001000;

        // Reset held with benign inputs: every enable must be low.
        for (int i = 0; i < 3; i++) cycle(1'b0, 6'b001000, 5'd1, 5'd2, 6'b000000, 5'd0, 1'b0, 1'b0);
        lit("reset_pc_we", 16'(a_pc_we), 16'd0);

        // Free-running pipeline.
        for (int i = 0; i < 4; i++) idle(1'b0);
        lit("run_pc_we", 16'(a_pc_we), 16'd1);
        lit("run_pipe_we", 16'(b_pipe_we), 16'd1);

        // Load-use: one bubble for dut_a, three for dut_b with a 2-cycle
        // memory freeze landing on dut_b's second bubble.
        hazard(1'b0);
        lit("lu_bubble_a", 16'(a_bub), 16'd1);
        lit("lu_pc_we_a", 16'(a_pc_we), 16'd0);
        idle(1'b1);
        lit("lu_stall_id_a", 16'(a_stall_id), 16'd1);
        lit("lu_freeze_b", 16'(b_bub), 16'd0);
        idle(1'b1);
        idle(1'b0);
        lit("lu_resume_b", 16'(b_bub), 16'd1);
        lit("lu_release_a", 16'(a_pc_we), 16'd0);
        idle(1'b0);
        lit("lu_last_b", 16'(b_bub), 16'd1);
        idle(1'b0);
        lit("lu_done_b", 16'(b_pc_we), 16'd1);
`ifdef HAZARD_PERF_CNT_EN
        lit("lu_cnt_a", a_cnt, 16'd1);
        lit("lu_cnt_b", b_cnt, 16'd3);
`else
        lit("lu_cnt_a", a_cnt, 16'd0);
        lit("lu_cnt_b", b_cnt, 16'd0);
`endif

        // No hazard: load to r0, and rt as a destination.
        cycle(1'b1, 6'b000000, 5'd1, 5'd0, 6'b100011, 5'd0, 1'b0, 1'b0);
        lit("nohaz_r0", 16'(a_pc_we), 16'd1);
        cycle(1'b1, 6'b100011, 5'd1, 5'd5, 6'b100011, 5'd5, 1'b0, 1'b0);
        lit("nohaz_rt_dest", 16'(a_pc_we), 16'd1);

        // Branch beats load-use.
        hazard(1'b1);
        lit("br_flush", 16'(a_flush), 16'd1);
        lit("br_pc_we", 16'(a_pc_we), 16'd1);
        lit("br_bubble", 16'(b_bub), 16'd0);

        // Branch during dut_b's stall drops the remaining bubbles.
        hazard(1'b0);
        cycle(1'b1, 6'b001000, 5'd1, 5'd2, 6'b000000, 5'd0, 1'b1, 1'b0);
        lit("stall_br_flush_b", 16'(b_flush), 16'd1);
        idle(1'b0);
        lit("stall_br_run_b", 16'(b_pc_we), 16'd1);

        // Memory busy 4 cycles: 5 frozen cycles.
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);
        lit("mw_release", 16'(a_pc_we), 16'd0);
        idle(1'b0);
        lit("mw_run", 16'(a_pc_we), 16'd1);

        // Reset in the middle of a freeze and in the middle of a stall.
        idle(1'b1);
        cycle(1'b0, 6'b001000, 5'd1, 5'd2, 6'b000000, 5'd0, 1'b0, 1'b1);
        idle(1'b0);
        lit("mw_reset_run", 16'(a_pc_we), 16'd1);
        hazard(1'b0);
        cycle(1'b0, 6'b001000, 5'd1, 5'd2, 6'b000000, 5'd0, 1'b0, 1'b0);
        lit("stall_reset_bub", 16'(b_bub), 16'd0);
        idle(1'b0);
        lit("stall_reset_run", 16'(b_pc_we), 16'd1);

        // Randomised traffic, small register range so matches are common.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) != 0) ? 6'b100011 : ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 6) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
